alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, selects arbitration: 1 = round-robin, 0 = fixed priority with requester 0 highest.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_a  input  16  (N=0,1) operand A, two's complement.
REQ-006 reqN_b  input  16  (N=0,1) operand B, two's complement.
REQ-007 reqN_sub  input  1  (N=0,1) 1 = A-B, 0 = A+B.
REQ-008 reqN_ready  output  1  (N=0,1) operation accepted this cycle when high with reqN_valid.
REQ-009 rspN_valid  output  1  (N=0,1) result for requester N available.
REQ-010 rspN_ready  input  1  (N=0,1) requester N consumes the result.
REQ-011 rsp_sum  output  16  saturated result, shared by both response channels.
REQ-012 rsp_flag  output  3  {sign, ovfl, zero} for rsp_sum.

Function
REQ-013 The block SHALL contain exactly one 16-bit add/sub datapath, time-shared between the two requesters.
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; the reset state is IDLE.
REQ-015 IDLE: grant SHALL be computed combinationally from the reqN_valid inputs; reqN_ready = (state==IDLE) && grant==N; at most one ready SHALL be high per cycle.
REQ-016 Grant with one valid: that requester; with none valid: none, and the FSM stays in IDLE.
REQ-017 Both valid, RR_EN=1: grant the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-018 Both valid, RR_EN=0: always grant requester 0.
REQ-019 On accept (valid && ready), the block SHALL capture a, b, sub and the owner ID, update the last-grant pointer, and go to EXEC.
REQ-020 EXEC: compute a + (sub ? ~b : b) + sub over 16 bits, register the result and flags, then go to RESP (one cycle).
REQ-021 Overflow: add: a[15]==b[15] && s[15]!=a[15]; sub: a[15]!=b[15] && s[15]!=a[15].
REQ-022 Saturation: on overflow, the result SHALL be 0x7FFF when a[15]==0 and 0x8000 when a[15]==1; otherwise the raw sum.
REQ-023 Flags: sign = result[15]; ovfl = overflow; zero = (result==0x0000); all flags SHALL be computed on the saturated result.
REQ-024 RESP: only the owner's rspN_valid SHALL be high; rsp_sum and rsp_flag SHALL hold stable until rspN_ready.
REQ-025 In RESP, both reqN_ready SHALL be low.
REQ-026 On the RESP handshake the FSM SHALL return to IDLE; no new accept occurs in that same cycle.
REQ-027 Latency: an accept in cycle T SHALL give rspN_valid in cycle T+2; minimum issue interval is 3 cycles.
REQ-028 rspN_ready asserted outside RESP, or by the non-owner, SHALL be ignored.
REQ-029 rsp_sum and rsp_flag outside RESP SHALL hold their last value (0 after reset).
REQ-030 A requester dropping valid before ready SHALL leave state unchanged, with no accept.

Reset
REQ-031 rst high at an edge SHALL force: state=IDLE, last-grant=1, rsp_sum=0x0000, rsp_flag=3'b000, all rspN_valid=0.
REQ-032 reqN_ready SHALL be 0 while rst is high.
REQ-033 Reset in EXEC or RESP SHALL discard the in-flight operation; no response is ever issued for it.

Verification
REQ-034 req0 0x0003+0x0004, accepted at T -> rsp0_valid at T+2, rsp_sum=0x0007, rsp_flag=3'b000.
REQ-035 req1 0x0005-0x0005 -> rsp1 sum=0x0000, flag=3'b001; req0 0x0000-0x0001 -> sum=0xFFFF, flag=3'b100.
REQ-036 Saturation: 0x7FFF+0x0001 -> 0x7FFF, flag 3'b010; 0x8000-0x0001 -> 0x8000, flag 3'b110; 0x8000+0x8000 -> 0x8000, flag 3'b110.
REQ-037 Both valid continuously, rspN_ready=1, RR_EN=1 -> grant order 0,1,0,1 from reset; with RR_EN=0 -> 0,0,0,0.
REQ-038 rsp1_ready held low 5 cycles in RESP -> rsp1_valid=1, sum/flag stable, both reqN_ready=0, and rsp1_ready pulses in EXEC are ignored.
REQ-039 rst asserted in EXEC -> next cycle all outputs 0 and no rsp for the discarded op; with both valid afterwards, the first grant goes to 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// alu_share_arbiter: two requesters sharing one saturating 16-bit add/sub unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_sub,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_sub,
  output logic        req1_ready,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_sum,
  output logic [2:0]  rsp_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic        owner_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        sub_q;
  logic [15:0] sum_q;
  logic [2:0]  flag_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;

  logic        w_gnt_any;
  logic        w_gnt_id;
  logic        w_accept;
  logic        w_rsp_done;
  logic [15:0] w_b_eff;
  logic [15:0] w_raw;
  logic        w_ovfl;
  logic [15:0] w_sat;
  logic [2:0]  w_flag;

  // last_q holds the most recent grant, so on contention ~last_q is the other one
  always_comb begin
    w_gnt_any = req0_valid | req1_valid;
    w_gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_id = RR_EN ? ~last_q : 1'b0;
    end else if (req1_valid) begin
      w_gnt_id = 1'b1;
    end
  end

  assign w_accept   = (state_q == IDLE) && w_gnt_any;
  assign req0_ready = !rst && w_accept && (w_gnt_id == 1'b0);
  assign req1_ready = !rst && w_accept && (w_gnt_id == 1'b1);
  assign w_rsp_done = (state_q == RESP) &&
                      ((owner_q == 1'b0) ? rsp0_ready : rsp1_ready);

  // The single shared adder: subtraction as a + ~b + 1
  always_comb begin
    w_b_eff = sub_q ? ~b_q : b_q;
    w_raw   = a_q + w_b_eff + {15'd0, sub_q};
    if (sub_q) begin
      w_ovfl = (a_q[15] != b_q[15]) && (w_raw[15] != a_q[15]);
    end else begin
      w_ovfl = (a_q[15] == b_q[15]) && (w_raw[15] != a_q[15]);
    end
    w_sat  = w_ovfl ? (a_q[15] ? 16'h8000 : 16'h7FFF) : w_raw;
    w_flag = {w_sat[15], w_ovfl, (w_sat == 16'h0000)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      sub_q        <= 1'b0;
      sum_q        <= 16'h0000;
      flag_q       <= 3'b000;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            a_q     <= w_gnt_id ? req1_a   : req0_a;
            b_q     <= w_gnt_id ? req1_b   : req0_b;
            sub_q   <= w_gnt_id ? req1_sub : req0_sub;
            owner_q <= w_gnt_id;
            last_q  <= w_gnt_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          sum_q        <= w_sat;
          flag_q       <= w_flag;
          rsp0_valid_q <= (owner_q == 1'b0);
          rsp1_valid_q <= (owner_q == 1'b1);
          state_q      <= RESP;
        end
        RESP: begin
          if (w_rsp_done) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_sum    = sum_q;
  assign rsp_flag   = flag_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// tb_alu_share_arbiter: scoreboard bench for the shared saturating ALU arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_sub, req1_sub;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_ready, rsp1_ready;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp_sum;
  logic [2:0]  rsp_flag;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [15:0] fp_rsp_sum;
  logic [2:0]  fp_rsp_flag;

  always #5 clk = ~clk;

  alu_share_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_flag(rsp_flag)
  );

  alu_share_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(fp_req1_ready),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(fp_rsp_sum), .rsp_flag(fp_rsp_flag)
  );

  typedef struct {
    int          id;
    logic [15:0] sum;
    logic [2:0]  flag;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference: exact signed arithmetic, clamped to the 16-bit range
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int          sa, sbv, r;
    logic        ov;
    logic [15:0] s;
    sa  = $signed(a);
    sbv = $signed(b);
    r   = sub ? (sa - sbv) : (sa + sbv);
    ov  = 1'b0;
    if (r > 32767) begin
      r  = 32767;
      ov = 1'b1;
    end else if (r < -32768) begin
      r  = -32768;
      ov = 1'b1;
    end
    s = r[15:0];
    return {s[15], ov, (s == 16'h0000), s};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [15:0] a, input logic [15:0] b, input logic sub);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
    end
  endtask

  // Present an op, wait (bounded) for ready, push the expectation, drop valid after accept
  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic sub, output bit ok);
    logic [18:0] m;
    exp_t        e;
    set_req(id, 1'b1, a, b, sub);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        m      = model(a, b, sub);
        e.id   = id;
        e.sum  = m[15:0];
        e.flag = m[18:16];
        e.acc  = cyc_cnt + 1;
        sb.push_back(e);
        cyc();
        set_req(id, 1'b0, a, b, sub);
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp0_valid || rsp1_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc();
    cyc();
    n_total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_flag, rsp_sum} !== 23'd0) $display("FAIL reset_outputs: got %h want 0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_flag, rsp_sum});
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_ops();
    logic [15:0] ta[6] = '{16'h0003, 16'h0005, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000};
    logic [15:0] tb[6] = '{16'h0004, 16'h0005, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
    logic        ts[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int          tid[6] = '{0, 1, 0, 0, 1, 0};
    logic [15:0] tsum[6] = '{16'h0007, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000};
    logic [2:0]  tflg[6] = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b110, 3'b110};
    logic [15:0] a, b, esum;
    logic [2:0]  eflg;
    logic        s;
    int          id;
    bit          ok;
    exp_t        e;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) begin
        a = ta[i]; b = tb[i]; s = ts[i]; id = tid[i];
      end else begin
        a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); id = int'($urandom_range(1, 0));
      end
      issue(id, a, b, s, ok);
      if (ok) wait_rsp(ok);
      n_total++;
      if (!ok || sb.size() == 0) begin
        $display("FAIL op%0d_timeout: no accept/response within budget, want response", i);
        sb.delete();
        continue;
      end
      n_pass++;
      e = sb.pop_front();
      esum = (i < 6) ? tsum[i] : e.sum;
      eflg = (i < 6) ? tflg[i] : e.flag;
      n_total++;
      if ({rsp1_valid, rsp0_valid, rsp_flag, rsp_sum} !== {(e.id == 1), (e.id == 0), eflg, esum})
        $display("FAIL op%0d_result: got v=%b%b flag=%b sum=%h want owner=%0d flag=%b sum=%h", i, rsp1_valid, rsp0_valid, rsp_flag, rsp_sum, e.id, eflg, esum);
      else n_pass++;
      n_total++;
      if (cyc_cnt - e.acc !== 1) $display("FAIL op%0d_latency: got %0d edges after accept want 1", i, cyc_cnt - e.acc);
      else n_pass++;
      if (e.id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      cyc();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    bit   ok;
    exp_t e;
    issue(1, 16'h1234, 16'h1111, 1'b0, ok);
    n_total++;
    if (!ok) $display("FAIL stall_accept: req1 not accepted, want accept");
    else n_pass++;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    cyc();
    rsp1_ready = 1'b0;
    set_req(0, 1'b1, 16'h0002, 16'h0003, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if ({rsp1_valid, rsp0_valid, req0_ready, req1_ready, rsp_flag, rsp_sum} !== {4'b1000, 3'b000, 16'h2345})
        $display("FAIL stall_hold%0d: got v=%b%b rdy=%b%b flag=%b sum=%h want v=10 rdy=00 flag=000 sum=2345", i, rsp1_valid, rsp0_valid, req0_ready, req1_ready, rsp_flag, rsp_sum);
      else n_pass++;
      cyc();
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    cyc();
    rsp1_ready = 1'b0;
    n_total++;
    if ({rsp1_valid, req0_ready, rsp_sum} !== {2'b01, 16'h2345})
      $display("FAIL stall_release: got rsp1_valid=%b req0_ready=%b sum=%h want 0 1 2345", rsp1_valid, req0_ready, rsp_sum);
    else n_pass++;
    if (sb.size() != 0) void'(sb.pop_front());
    issue(0, 16'h0002, 16'h0003, 1'b0, ok);
    if (ok) wait_rsp(ok);
    n_total++;
    if (!ok || sb.size() == 0) begin
      $display("FAIL stall_followup: no response, want rsp0");
      sb.delete();
      return;
    end
    e = sb.pop_front();
    if ({rsp0_valid, rsp_sum} !== {1'b1, e.sum}) $display("FAIL stall_followup: got v=%b sum=%h want 1 %h", rsp0_valid, rsp_sum, e.sum);
    else n_pass++;
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_drop();
    bit   ok;
    bit   spurious = 1'b0;
    exp_t e;
    issue(0, 16'h0100, 16'h0001, 1'b1, ok);
    set_req(1, 1'b1, 16'h0055, 16'h0001, 1'b0);
    cyc();
    set_req(1, 1'b0, 16'h0055, 16'h0001, 1'b0);
    wait_rsp(ok);
    n_total++;
    if (!ok || sb.size() == 0 || !rsp0_valid) begin
      $display("FAIL drop_rsp0: no rsp0, want rsp0 sum=00ff");
      sb.delete();
      return;
    end
    e = sb.pop_front();
    if (rsp_sum !== e.sum) $display("FAIL drop_rsp0: got sum=%h want %h", rsp_sum, e.sum);
    else n_pass++;
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp0_valid || rsp1_valid || rsp_sum !== 16'h00FF) spurious = 1'b1;
      cyc();
    end
    n_total++;
    if (spurious) $display("FAIL drop_no_accept: got activity after dropped req1 want idle with sum=00ff");
    else n_pass++;
  endtask

  task automatic test_reset_exec();
    bit ok;
    bit spurious = 1'b0;
    issue(0, 16'h1111, 16'h2222, 1'b0, ok);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc();
    n_total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_flag, rsp_sum} !== 23'd0)
      $display("FAIL reset_exec_outputs: got %h want 0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_flag, rsp_sum});
    else n_pass++;
    sb.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp0_valid || rsp1_valid) spurious = 1'b1;
      cyc();
    end
    n_total++;
    if (spurious) $display("FAIL reset_exec_discard: got a response for the discarded op want none");
    else n_pass++;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL reset_exec_first_grant: got ready=%b%b want 10", req0_ready, req1_ready);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int          g[4], gf[4];
    int          ng = 0, ngf = 0, nrsp = 0;
    bit          multi = 1'b0;
    logic [18:0] m;
    exp_t        e;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(0, 1'b1, 16'h0010, 16'h0001, 1'b0);
    set_req(1, 1'b1, 16'h0020, 16'h0003, 1'b1);
    for (int i = 0; i < 40 && nrsp < 4; i++) begin
      #1;
      if (req0_ready && req1_ready) multi = 1'b1;
      if (req0_ready || req1_ready) begin
        if (ng < 4) g[ng] = req1_ready ? 1 : 0;
        ng++;
        m = req1_ready ? model(16'h0020, 16'h0003, 1'b1) : model(16'h0010, 16'h0001, 1'b0);
        e.id = req1_ready ? 1 : 0; e.sum = m[15:0]; e.flag = m[18:16]; e.acc = cyc_cnt + 1;
        sb.push_back(e);
      end
      if (fp_req0_ready || fp_req1_ready) begin
        if (ngf < 4) gf[ngf] = fp_req1_ready ? 1 : 0;
        ngf++;
      end
      if ((rsp0_valid || rsp1_valid) && sb.size() != 0) begin
        e = sb.pop_front();
        n_total++;
        if ({rsp1_valid, rsp0_valid, rsp_flag, rsp_sum} !== {(e.id == 1), (e.id == 0), e.flag, e.sum})
          $display("FAIL b2b_rsp%0d: got v=%b%b flag=%b sum=%h want owner=%0d flag=%b sum=%h", nrsp, rsp1_valid, rsp0_valid, rsp_flag, rsp_sum, e.id, e.flag, e.sum);
        else n_pass++;
        nrsp++;
      end
      @(posedge clk);
    end
    #1;
    n_total++;
    if (ng < 4 || ngf < 4 || nrsp < 4 || multi) begin
      $display("FAIL b2b_progress: got grants=%0d fp_grants=%0d rsps=%0d multi_ready=%b want >=4 >=4 4 0", ng, ngf, nrsp, multi);
    end else begin
      n_pass++;
      n_total++;
      if ({g[0][0], g[1][0], g[2][0], g[3][0]} !== 4'b0101) $display("FAIL b2b_rr_order: got %0d%0d%0d%0d want 0101", g[0], g[1], g[2], g[3]);
      else n_pass++;
      n_total++;
      if ({gf[0][0], gf[1][0], gf[2][0], gf[3][0]} !== 4'b0000) $display("FAIL b2b_fixed_order: got %0d%0d%0d%0d want 0000", gf[0], gf[1], gf[2], gf[3]);
      else n_pass++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    sb.delete();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    test_reset();
    test_ops();
    test_stall();
    test_drop();
    test_reset_exec();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
